// File: rtl/rv_pkg.sv
// Shared core constants for the TIMER opcode path, plus the timer enable-state type.
package rv_pkg;

    localparam logic [6:0] OPC_TIMER   = 7'b0100101;

    localparam logic [2:0] TIM_EN      = 3'b000;
    localparam logic [2:0] TIM_PSC_I   = 3'b001;
    localparam logic [2:0] TIM_ARR_I   = 3'b010;
    localparam logic [2:0] TIM_PSC_REG = 3'b100;
    localparam logic [2:0] TIM_ARR_REG = 3'b101;
    localparam logic [2:0] TIM_DIS     = 3'b111;

    localparam logic [5:0] ALU_TIM_PSC = 6'b100001;
    localparam logic [5:0] ALU_TIM_ARR = 6'b100010;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } tim_state_t;

    function automatic logic is_psc_write(input logic [2:0] funct3);
        return (funct3 == TIM_PSC_I) || (funct3 == TIM_PSC_REG);
    endfunction

    function automatic logic is_arr_write(input logic [2:0] funct3);
        return (funct3 == TIM_ARR_I) || (funct3 == TIM_ARR_REG);
    endfunction

endpackage

// File: rtl/timer_unit_if.sv
// Command and status bundle between the control unit and the timer peripheral.
interface timer_unit_if #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 12
);
    logic             cmd_valid;
    logic [2:0]       cmd_funct3;
    logic             timer_read_reg;
    logic [31:0]      rs1_data;
    logic [IMM_W-1:0] imm;
    logic             uif_clr;

    logic [WIDTH-1:0] cnt_o;
    logic [WIDTH-1:0] psc_o;
    logic [WIDTH-1:0] arr_o;
    logic             running_o;
    logic             uif_o;
    logic             irq_o;

    modport master (
        output cmd_valid, cmd_funct3, timer_read_reg, rs1_data, imm, uif_clr,
        input  cnt_o, psc_o, arr_o, running_o, uif_o, irq_o
    );

    modport slave (
        input  cmd_valid, cmd_funct3, timer_read_reg, rs1_data, imm, uif_clr,
        output cnt_o, psc_o, arr_o, running_o, uif_o, irq_o
    );
endinterface

// File: rtl/timer_unit_prescaler.sv
// Prescaler counter: emits a tick on the cycle psc_cnt reaches the active PSC value.
module tim_prescaler #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clr,
    input  logic [WIDTH-1:0] psc,
    output logic             tick,
    output logic [WIDTH-1:0] psc_cnt
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    assign tick = run && (psc_cnt == psc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_cnt <= '0;
        end else if (clr || tick) begin
            psc_cnt <= '0;
        end else if (run) begin
            psc_cnt <= psc_cnt + ONE;
        end
    end
endmodule

// File: rtl/timer_unit.sv
// Prescaled auto-reload timer driven by TIMER-opcode commands from the control unit.
//   state   | meaning
//   ST_STOP | counters hold; PSC/ARR writes land in preload and active together
//   ST_RUN  | counting; PSC/ARR writes land in preload, copied on update event
module timer_unit
    import rv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IMM_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    timer_unit_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    tim_state_t       state, state_nxt;
    logic             running;
    logic             is_en, is_dis, wr_psc, wr_arr;
    logic             counting, tick, upd;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] psc_cnt, cnt;
    logic [WIDTH-1:0] psc_act, psc_pre, arr_act, arr_pre;
    logic             uif, irq;
    logic             unused_rs1_hi;

    assign unused_rs1_hi = &{1'b0, bus.rs1_data[31:WIDTH]};

    assign is_en   = bus.cmd_valid && (bus.cmd_funct3 == TIM_EN);
    assign is_dis  = bus.cmd_valid && (bus.cmd_funct3 == TIM_DIS);
    assign wr_psc  = bus.cmd_valid && is_psc_write(bus.cmd_funct3);
    assign wr_arr  = bus.cmd_valid && is_arr_write(bus.cmd_funct3);
    assign operand = bus.timer_read_reg ? bus.rs1_data[WIDTH-1:0]
                                        : {{(WIDTH-IMM_W){1'b0}}, bus.imm};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_STOP;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        running   = (state == ST_RUN);
        if (is_en)  state_nxt = ST_RUN;
        if (is_dis) state_nxt = ST_STOP;
    end

    // DIS freezes the counters in its own cycle so cnt_o holds the value seen when it was issued.
    assign counting = running && !is_dis;
    assign upd      = tick && (cnt == arr_act);

    tim_prescaler #(.WIDTH(WIDTH)) u_psc (
        .clk     (clk),
        .reset   (reset),
        .run     (counting),
        .clr     (wr_psc && !running),
        .psc     (psc_act),
        .tick    (tick),
        .psc_cnt (psc_cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            psc_act <= '0;
            psc_pre <= '0;
            arr_act <= '0;
            arr_pre <= '0;
            uif     <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (upd)       cnt <= '0;
            else if (tick) cnt <= cnt + ONE;

            if (wr_psc)                    psc_pre <= operand;
            if (wr_psc && (!running || upd)) psc_act <= operand;
            else if (upd)                  psc_act <= psc_pre;

            if (wr_arr)                    arr_pre <= operand;
            if (wr_arr && (!running || upd)) arr_act <= operand;
            else if (upd)                  arr_act <= arr_pre;

            irq <= upd;
            uif <= upd || (uif && !bus.uif_clr);
        end
    end

    assign bus.cnt_o     = cnt;
    assign bus.psc_o     = psc_act;
    assign bus.arr_o     = arr_act;
    assign bus.running_o = running;
    assign bus.uif_o     = uif;
    assign bus.irq_o     = irq;
endmodule

// File: tb/tb_timer_unit.sv
// Randomized scoreboard bench for timer_unit against a behavioural timer model.
module tb_timer_unit;
    localparam int WIDTH = 16;
    localparam int IMM_W = 12;
    localparam int MODV  = 1 << WIDTH;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    timer_unit_if #(.WIDTH(WIDTH), .IMM_W(IMM_W)) tif ();

    timer_unit #(.WIDTH(WIDTH), .IMM_W(IMM_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tif)
    );

    typedef struct {
        int cnt;
        int psc;
        int arr;
        bit run;
        bit uif;
        bit irq;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int m_pc, m_cnt, m_psc, m_arr, m_ppre, m_apre;
    bit m_run, m_uif, m_irq;

    function automatic void model_reset();
        m_pc = 0; m_cnt = 0; m_psc = 0; m_arr = 0; m_ppre = 0; m_apre = 0;
        m_run = 0; m_uif = 0; m_irq = 0;
    endfunction

    function automatic void model_step(bit v, int f3, bit rr, logic [31:0] rs1, int imm, bit clr);
        int op;
        bit en, dis, wp, wa, tick, upd, was_run;
        en  = v && (f3 == 0);
        dis = v && (f3 == 7);
        wp  = v && (f3 == 1 || f3 == 4);
        wa  = v && (f3 == 2 || f3 == 5);
        op  = rr ? int'(rs1[15:0]) : imm;
        was_run = m_run;
        tick = 0;
        upd  = 0;
        if (m_run && !dis) begin
            if (m_pc == m_psc) begin tick = 1; m_pc = 0; end
            else m_pc = (m_pc + 1) % MODV;
        end
        if (tick) begin
            if (m_cnt == m_arr) begin
                upd = 1; m_cnt = 0; m_psc = m_ppre; m_arr = m_apre;
            end else m_cnt = (m_cnt + 1) % MODV;
        end
        if (wp) begin
            m_ppre = op;
            if (!was_run || upd) m_psc = op;
            if (!was_run) m_pc = 0;
        end
        if (wa) begin
            m_apre = op;
            if (!was_run || upd) m_arr = op;
        end
        if (en)  m_run = 1;
        if (dis) m_run = 0;
        m_irq = upd;
        m_uif = upd ? 1'b1 : (clr ? 1'b0 : m_uif);
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.cnt = m_cnt; o.psc = m_psc; o.arr = m_arr;
        o.run = m_run; o.uif = m_uif; o.irq = m_irq;
        return o;
    endfunction

    task automatic drive(bit v, int f3, bit rr, logic [31:0] rs1, int imm, bit clr);
        @(negedge clk);
        tif.cmd_valid      = v;
        tif.cmd_funct3     = 3'(f3);
        tif.timer_read_reg = rr;
        tif.rs1_data       = rs1;
        tif.imm            = IMM_W'(imm);
        tif.uif_clr        = clr;
        model_step(v, f3, rr, rs1, imm, clr);
        exp_q.push_back(model_obs());
    endtask

    task automatic idle(int n, int clr_at = -1);
        for (int i = 1; i <= n; i++) drive(0, 0, 0, 32'h0, 0, (i == clr_at) || (i == clr_at + 1));
    endtask

    task automatic check_zero(string name);
        checks++;
        if (tif.cnt_o != 0 || tif.psc_o != 0 || tif.arr_o != 0 ||
            tif.running_o || tif.uif_o || tif.irq_o) begin
            errors++;
            $display("FAIL %s: got cnt=%0d psc=%0d arr=%0d run=%0b uif=%0b irq=%0b, expected all zero",
                     name, tif.cnt_o, tif.psc_o, tif.arr_o, tif.running_o, tif.uif_o, tif.irq_o);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        tif.cmd_valid = 0;
        tif.uif_clr   = 0;
        #2 reset = 1'b0;
        #1 check_zero("async_reset");
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (int'(tif.cnt_o) != e.cnt || int'(tif.psc_o) != e.psc || int'(tif.arr_o) != e.arr ||
                    tif.running_o != e.run || tif.uif_o != e.uif || tif.irq_o != e.irq) begin
                    errors++;
                    $display("FAIL outputs @%0t: got cnt=%0d psc=%0d arr=%0d run=%0b uif=%0b irq=%0b, expected cnt=%0d psc=%0d arr=%0d run=%0b uif=%0b irq=%0b",
                             $time, tif.cnt_o, tif.psc_o, tif.arr_o, tif.running_o, tif.uif_o, tif.irq_o,
                             e.cnt, e.psc, e.arr, e.run, e.uif, e.irq);
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] rs1;
        int imm, r;
        tif.cmd_valid = 0; tif.cmd_funct3 = 0; tif.timer_read_reg = 0;
        tif.rs1_data = 0; tif.imm = 0; tif.uif_clr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("power_on_reset");
        reset = 1'b1;

        // PSC=2, ARR=3: update 12 clocks after EN; uif_clr in the update cycle and the next one
        drive(1, 1, 0, 32'h0, 2, 0);
        drive(1, 2, 0, 32'h0, 3, 0);
        drive(1, 0, 0, 32'h0, 0, 0);
        idle(16, 12);
        // ARR preload while running, register operand with upper junk
        drive(1, 5, 1, 32'hABCD_0005, 0, 0);
        idle(30);
        // DIS mid-period, hold, resume
        idle(5);
        drive(1, 7, 0, 32'h0, 0, 0);
        idle(4);
        drive(1, 0, 0, 32'h0, 0, 0);
        idle(10);
        do_reset();
        idle(5);
        // PSC=0, ARR=0: update every cycle
        drive(1, 1, 0, 32'h0, 0, 0);
        drive(1, 2, 0, 32'h0, 0, 0);
        drive(1, 0, 0, 32'h0, 0, 0);
        idle(6);

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                do_reset();
            end else begin
                rs1 = $urandom;
                if ($urandom_range(0, 3) != 0) rs1[15:0] = 16'($urandom_range(0, 5));
                imm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4095))
                                                  : int'($urandom_range(0, 5));
                drive(r < 25, int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                      rs1, imm, $urandom_range(0, 4) == 0);
            end
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
